fir_tap_bram_arbiter: RTL and testbench
=======================================

Name: fir_tap_bram_arbiter

Overview:
- Shares the single-port tap coefficient BRAM between two requesters:
  - the AXI-Lite configuration path (cfg), which does coefficient writes and readback;
  - the FIR MAC engine (eng), which reads coefficients.
- Lets cfg readback proceed while the filter runs, without starving the engine.
- Sits between the FIR control/datapath and the tap BRAM pins.
- Owns arbitration, range checking and read-response routing for BRAM read latency 1.

Parameters:
- pADDR_WIDTH, 12, byte-address width of requests and BRAM.
- pDATA_WIDTH, 32, data width.
- pDepth, 11, number of 4-byte coefficient words (legal byte addresses 0x00..(pDepth-1)*4).
- pMaxStarve, 4, maximum consecutive engine wins over a waiting cfg request during an engine burst.

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- cfg_req_valid  in  1  cfg request pending
- cfg_req_we  in  1  1 = write, 0 = read
- cfg_req_addr  in  pADDR_WIDTH  byte address
- cfg_req_wdata  in  pDATA_WIDTH  write data
- cfg_req_ready  out  1  cfg request accepted this cycle
- cfg_rsp_valid  out  1  cfg read data valid
- cfg_rsp_rdata  out  pDATA_WIDTH  cfg read data
- eng_req_valid, eng_req_we, eng_req_addr, eng_req_wdata, eng_req_ready, eng_rsp_valid, eng_rsp_rdata  same directions, widths and meaning as cfg_*
- eng_burst  in  1  engine is inside a MAC burst; raises engine priority
- bram_WE  out  4  byte write enables
- bram_EN  out  1  BRAM enable
- bram_Di  out  pDATA_WIDTH  BRAM write data
- bram_A  out  pADDR_WIDTH  BRAM byte address
- bram_Do  in  pDATA_WIDTH  BRAM read data, valid one cycle after the address
- conflict_cnt  out  16  saturating count of cycles with both requests valid

Behaviour:
- Clocking and reset: one clock, axis_clk. Reset axis_rst_n is asynchronous and active-low.
- Reset state:
  - all registered outputs 0; conflict_cnt 0;
  - pending response dropped (rsp_valid 0 immediately on reset assertion);
  - last_grant = cfg; starve_cnt = 0.
- Request protocol: a requester holds valid/we/addr/wdata stable until ready. Ready is combinational, in the same cycle as the grant.
- Grant rules:
  - Only one valid: that requester wins.
  - Both valid, eng_burst=1, starve_cnt < pMaxStarve: eng wins and starve_cnt increments.
  - Both valid, eng_burst=1, starve_cnt == pMaxStarve: cfg wins and starve_cnt clears.
  - Both valid, eng_burst=0: round-robin; the winner is the requester that is not last_grant.
  - starve_cnt also clears whenever cfg_req_valid=0 or cfg is granted.
  - last_grant updates on every grant.
- BRAM drive (combinational from the grant):
  - bram_EN = 1 if any grant, else 0.
  - bram_A = granted address.
  - bram_WE = 4'hf only for a granted, in-range write; otherwise 0.
  - bram_Di = granted wdata, else 0.
  - With no grant: bram_A = 0, bram_WE = 0.
- In-range test: addr < pDepth*4 and addr[1:0] == 0.
  - Out-of-range or misaligned requests are still accepted (ready = 1).
  - Such writes are dropped.
  - Such reads return 0.
- Read response:
  - An accepted read registers owner and an oor flag.
  - The next cycle, exactly one of cfg_rsp_valid/eng_rsp_valid pulses for 1 cycle.
  - That port's rsp_rdata = oor ? 0 : bram_Do. The other port's rsp_rdata = 0.
  - No response for writes.
  - Back-to-back reads are fully pipelined at 1 per cycle. There is no response backpressure.
- Simultaneous read and write from different requesters: only the winner is issued. The loser waits with ready=0.
- conflict_cnt: increments each cycle with both valid; saturates at 0xFFFF.

Decomposition:
- Shared fir_pkg:
  - requester ID encoding (REQ_CFG=0, REQ_ENG=1);
  - word size constant 4;
  - WE_ALL = 4'hf.
- No sub-module; the grant logic, response pipeline and counters fit in one module.

Test Plan:
- Write then read back: cfg write 0x04 ← 0x12345678 alone → ready same cycle, bram_WE=f, A=0x04. Then cfg read 0x04 → cfg_rsp_valid next cycle with rdata 0x12345678; eng_rsp_valid stays 0.
- Round-robin: eng_burst=0, both read continuously for 4 cycles from reset → grant order eng, cfg, eng, cfg; conflict_cnt=4.
- Starvation limit: eng_burst=1, both valid for 10 cycles, pMaxStarve=4 → eng×4, cfg×1, eng×4, cfg×1.
- Range check with pDepth=11:
  - cfg write 0x2C → ready 1, bram_WE=0;
  - read 0x2C → rsp 0;
  - read 0x06 → rsp 0;
  - read 0x28 after writing 0xA5 → rsp 0xA5.
- Pipelined engine reads: eng reads 0x00..0x28 on consecutive cycles → 11 consecutive eng_rsp_valid pulses, data in address order.
- Reset mid-operation: axis_rst_n low in the cycle after an accepted read → rsp_valid drops immediately and no response follows release; the first post-reset tie goes to eng.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap-coefficient BRAM path: requester IDs and word constants.
package fir_pkg;

  typedef enum logic {
    REQ_CFG = 1'b0,
    REQ_ENG = 1'b1
  } req_id_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WE_ALL     = 4'hf;

endpackage

// File: rtl/fir_tap_bram_arbiter.sv
// Arbitrates the single-port tap BRAM between the cfg (AXI-Lite) and engine requesters,
// range-checks each access and routes the latency-1 read data back to its owner.
module fir_tap_bram_arbiter
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDepth      = 11,
  parameter int unsigned pMaxStarve  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,

  input  logic                   cfg_req_valid,
  input  logic                   cfg_req_we,
  input  logic [pADDR_WIDTH-1:0] cfg_req_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_req_wdata,
  output logic                   cfg_req_ready,
  output logic                   cfg_rsp_valid,
  output logic [pDATA_WIDTH-1:0] cfg_rsp_rdata,

  input  logic                   eng_req_valid,
  input  logic                   eng_req_we,
  input  logic [pADDR_WIDTH-1:0] eng_req_addr,
  input  logic [pDATA_WIDTH-1:0] eng_req_wdata,
  output logic                   eng_req_ready,
  output logic                   eng_rsp_valid,
  output logic [pDATA_WIDTH-1:0] eng_rsp_rdata,

  input  logic                   eng_burst,

  output logic [3:0]             bram_WE,
  output logic                   bram_EN,
  output logic [pDATA_WIDTH-1:0] bram_Di,
  output logic [pADDR_WIDTH-1:0] bram_A,
  input  logic [pDATA_WIDTH-1:0] bram_Do,

  output logic [15:0]            conflict_cnt
);

  localparam int unsigned          SW         = (pMaxStarve < 1) ? 1 : $clog2(pMaxStarve + 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(pMaxStarve);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LIMIT = pADDR_WIDTH'(pDepth * WORD_BYTES);
  localparam logic [15:0]          CNT_SAT    = 16'hffff;

  req_id_e                  last_grant_q, last_grant_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     cfg_rsp_valid_q, cfg_rsp_valid_d;
  logic                     eng_rsp_valid_q, eng_rsp_valid_d;
  logic                     rsp_oor_q, rsp_oor_d;
  logic [15:0]              conflict_q, conflict_d;

  logic                     both_valid;
  logic                     gnt_cfg, gnt_eng, gnt_any;
  logic                     sel_we, sel_in_range;
  logic [pADDR_WIDTH-1:0]   sel_addr;
  logic [pDATA_WIDTH-1:0]   sel_wdata;

  assign both_valid = cfg_req_valid & eng_req_valid;

  // Grant selection: burst priority with starvation cap, otherwise round-robin on ties.
  always_comb begin
    gnt_cfg  = 1'b0;
    gnt_eng  = 1'b0;
    starve_d = starve_q;
    if (both_valid) begin
      if (eng_burst) begin
        if (starve_q >= STARVE_MAX) begin
          gnt_cfg = 1'b1;
        end else begin
          gnt_eng  = 1'b1;
          starve_d = starve_q + SW'(1);
        end
      end else if (last_grant_q == REQ_CFG) begin
        gnt_eng = 1'b1;
      end else begin
        gnt_cfg = 1'b1;
      end
    end else if (cfg_req_valid) begin
      gnt_cfg = 1'b1;
    end else if (eng_req_valid) begin
      gnt_eng = 1'b1;
    end
    if (!cfg_req_valid || gnt_cfg) begin
      starve_d = '0;
    end
  end

  assign gnt_any       = gnt_cfg | gnt_eng;
  assign cfg_req_ready = gnt_cfg;
  assign eng_req_ready = gnt_eng;

  always_comb begin
    sel_we       = gnt_eng ? eng_req_we    : cfg_req_we;
    sel_addr     = gnt_eng ? eng_req_addr  : cfg_req_addr;
    sel_wdata    = gnt_eng ? eng_req_wdata : cfg_req_wdata;
    sel_in_range = (sel_addr < ADDR_LIMIT) && (sel_addr[1:0] == 2'b00);
  end

  // BRAM pins follow the grant in the same cycle; out-of-range writes never reach the array.
  always_comb begin
    bram_EN = gnt_any;
    bram_A  = gnt_any ? sel_addr  : '0;
    bram_Di = gnt_any ? sel_wdata : '0;
    bram_WE = (gnt_any && sel_we && sel_in_range) ? WE_ALL : 4'h0;
  end

  always_comb begin
    last_grant_d    = last_grant_q;
    cfg_rsp_valid_d = 1'b0;
    eng_rsp_valid_d = 1'b0;
    rsp_oor_d       = 1'b0;
    conflict_d      = conflict_q;
    if (gnt_cfg) begin
      last_grant_d = REQ_CFG;
    end else if (gnt_eng) begin
      last_grant_d = REQ_ENG;
    end
    if (gnt_any && !sel_we) begin
      cfg_rsp_valid_d = gnt_cfg;
      eng_rsp_valid_d = gnt_eng;
      rsp_oor_d       = !sel_in_range;
    end
    if (both_valid && (conflict_q != CNT_SAT)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      last_grant_q    <= REQ_CFG;
      starve_q        <= '0;
      cfg_rsp_valid_q <= 1'b0;
      eng_rsp_valid_q <= 1'b0;
      rsp_oor_q       <= 1'b0;
      conflict_q      <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      starve_q        <= starve_d;
      cfg_rsp_valid_q <= cfg_rsp_valid_d;
      eng_rsp_valid_q <= eng_rsp_valid_d;
      rsp_oor_q       <= rsp_oor_d;
      conflict_q      <= conflict_d;
    end
  end

  // Read data arrives from the BRAM one cycle after issue; only the owner sees it.
  always_comb begin
    cfg_rsp_rdata = (cfg_rsp_valid_q && !rsp_oor_q) ? bram_Do : '0;
    eng_rsp_rdata = (eng_rsp_valid_q && !rsp_oor_q) ? bram_Do : '0;
  end

  assign cfg_rsp_valid = cfg_rsp_valid_q;
  assign eng_rsp_valid = eng_rsp_valid_q;
  assign conflict_cnt  = conflict_q;

endmodule

// File: tb/tb_fir_tap_bram_arbiter.sv
// Directed, table-driven bench for fir_tap_bram_arbiter with a latency-1 BRAM model.
module tb_fir_tap_bram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cfg_req_valid, cfg_req_we, cfg_req_ready, cfg_rsp_valid;
  logic [11:0] cfg_req_addr;
  logic [31:0] cfg_req_wdata, cfg_rsp_rdata;
  logic        eng_req_valid, eng_req_we, eng_req_ready, eng_rsp_valid;
  logic [11:0] eng_req_addr;
  logic [31:0] eng_req_wdata, eng_rsp_rdata;
  logic        eng_burst;
  logic [3:0]  bram_WE;
  logic        bram_EN;
  logic [31:0] bram_Di, bram_Do;
  logic [11:0] bram_A;
  logic [15:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cur   = 0;

  fir_tap_bram_arbiter dut (
    .axis_clk      (clk),
    .axis_rst_n    (rst_n),
    .cfg_req_valid (cfg_req_valid),
    .cfg_req_we    (cfg_req_we),
    .cfg_req_addr  (cfg_req_addr),
    .cfg_req_wdata (cfg_req_wdata),
    .cfg_req_ready (cfg_req_ready),
    .cfg_rsp_valid (cfg_rsp_valid),
    .cfg_rsp_rdata (cfg_rsp_rdata),
    .eng_req_valid (eng_req_valid),
    .eng_req_we    (eng_req_we),
    .eng_req_addr  (eng_req_addr),
    .eng_req_wdata (eng_req_wdata),
    .eng_req_ready (eng_req_ready),
    .eng_rsp_valid (eng_rsp_valid),
    .eng_rsp_rdata (eng_rsp_rdata),
    .eng_burst     (eng_burst),
    .bram_WE       (bram_WE),
    .bram_EN       (bram_EN),
    .bram_Di       (bram_Di),
    .bram_A        (bram_A),
    .bram_Do       (bram_Do),
    .conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM, read data one cycle after the address; preloaded with C0DE00<index>.
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    bram_Do = 32'h0;
  end
  always @(posedge clk) begin
    if (bram_EN) begin
      if (bram_WE == 4'hf) mem[bram_A[11:2]] <= bram_Di;
      bram_Do <= mem[bram_A[11:2]];
    end
  end

  typedef struct {
    logic        cv, cwe;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        ev, ewe;
    logic [11:0] ea;
    logic [31:0] ed;
    logic        b;
    logic        x_cr, x_er, x_en;
    logic [3:0]  x_we;
    logic [11:0] x_a;
    logic [31:0] x_di;
    logic        x_crv;
    logic [31:0] x_crd;
    logic        x_erv;
    logic [31:0] x_erd;
    logic [15:0] x_cc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int cv, int cwe, int ca, int cd, int ev, int ewe, int ea, int ed,
                              int b, int xcr, int xer, int xen, int xwe, int xa, int xdi,
                              int xcrv, int xcrd, int xerv, int xerd, int xcc);
    vec_t v;
    v.cv = 1'(cv);   v.cwe = 1'(cwe); v.ca = 12'(ca); v.cd = 32'(cd);
    v.ev = 1'(ev);   v.ewe = 1'(ewe); v.ea = 12'(ea); v.ed = 32'(ed);
    v.b  = 1'(b);
    v.x_cr = 1'(xcr); v.x_er = 1'(xer); v.x_en = 1'(xen); v.x_we = 4'(xwe);
    v.x_a  = 12'(xa); v.x_di = 32'(xdi);
    v.x_crv = 1'(xcrv); v.x_crd = 32'(xcrd); v.x_erv = 1'(xerv); v.x_erd = 32'(xerd);
    v.x_cc = 16'(xcc);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, cur, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    cfg_req_valid = v.cv; cfg_req_we = v.cwe; cfg_req_addr = v.ca; cfg_req_wdata = v.cd;
    eng_req_valid = v.ev; eng_req_we = v.ewe; eng_req_addr = v.ea; eng_req_wdata = v.ed;
    eng_burst     = v.b;
  endtask

  task automatic idle_inputs();
    apply(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 0,0,0,0, 0));
  endtask

  task automatic check_vec(input vec_t v);
    chk("cfg_req_ready", 32'(cfg_req_ready), 32'(v.x_cr));
    chk("eng_req_ready", 32'(eng_req_ready), 32'(v.x_er));
    chk("bram_EN",       32'(bram_EN),       32'(v.x_en));
    chk("bram_WE",       32'(bram_WE),       32'(v.x_we));
    chk("bram_A",        32'(bram_A),        32'(v.x_a));
    chk("bram_Di",       bram_Di,            v.x_di);
    chk("cfg_rsp_valid", 32'(cfg_rsp_valid), 32'(v.x_crv));
    chk("cfg_rsp_rdata", cfg_rsp_rdata,      v.x_crd);
    chk("eng_rsp_valid", 32'(eng_rsp_valid), 32'(v.x_erv));
    chk("eng_rsp_rdata", eng_rsp_rdata,      v.x_erd);
    chk("conflict_cnt",  32'(conflict_cnt),  32'(v.x_cc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_pipe [11];

  initial begin
    // Columns: cfg{v,we,a,d} eng{v,we,a,d} burst | ready{c,e} EN WE A Di | cfg_rsp{v,d} eng_rsp{v,d} conflict
    vq.push_back(mk(0,0,0,0,             0,0,0,0, 0, 0,0,0,0,0,0,                    0,0,0,0, 0));
    vq.push_back(mk(1,1,'h04,'h12345678, 0,0,0,0, 0, 1,0,1,'hf,'h04,'h12345678,      0,0,0,0, 0));
    vq.push_back(mk(1,0,'h04,0,          0,0,0,0, 0, 1,0,1,0,'h04,0,                 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,             0,0,0,0, 0, 0,0,0,0,0,0,                    1,'h12345678,0,0, 0));
    vq.push_back(mk(1,1,'h2C,'hBAD,      0,0,0,0, 0, 1,0,1,0,'h2C,'hBAD,             0,0,0,0, 0));
    vq.push_back(mk(1,0,'h2C,0,          0,0,0,0, 0, 1,0,1,0,'h2C,0,                 0,0,0,0, 0));
    vq.push_back(mk(1,0,'h06,0,          0,0,0,0, 0, 1,0,1,0,'h06,0,                 1,0,0,0, 0));
    vq.push_back(mk(1,1,'h28,'hA5,       0,0,0,0, 0, 1,0,1,'hf,'h28,'hA5,            1,0,0,0, 0));
    vq.push_back(mk(1,0,'h28,0,          0,0,0,0, 0, 1,0,1,0,'h28,0,                 0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,             0,0,0,0, 0, 0,0,0,0,0,0,                    1,'hA5,0,0, 0));
    // Round-robin ties: eng, cfg, eng, cfg
    vq.push_back(mk(1,0,0,0,     1,0,'h08,0, 0, 0,1,1,0,'h08,0, 0,0,0,0, 0));
    vq.push_back(mk(1,0,0,0,     1,0,'h0C,0, 0, 1,0,1,0,0,0,    0,0,1,'hC0DE0002, 1));
    vq.push_back(mk(1,0,'h10,0,  1,0,'h0C,0, 0, 0,1,1,0,'h0C,0, 1,'hC0DE0000,0,0, 2));
    vq.push_back(mk(1,0,'h10,0,  1,0,'h14,0, 0, 1,0,1,0,'h10,0, 0,0,1,'hC0DE0003, 3));
    vq.push_back(mk(0,0,0,0,     0,0,0,0,    0, 0,0,0,0,0,0,    1,'hC0DE0004,0,0, 4));
    // Burst with starvation cap: eng x4, cfg x1, eng x4, cfg x1
    for (int k = 0; k < 10; k++) begin
      int cg, er;
      cg = int'(k == 4 || k == 9);
      er = int'(k != 0 && k != 5);
      vq.push_back(mk(1,0,'h20,0, 1,0,'h24,0, 1, cg, 1 - cg, 1, 0, (cg != 0) ? 'h20 : 'h24, 0,
                      int'(k == 5), (k == 5) ? 'hC0DE0008 : 0, er, (er != 0) ? 'hC0DE0009 : 0, 4 + k));
    end
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0, 1,'hC0DE0008,0,0, 14));
    // Starvation count clears when cfg drops its request
    vq.push_back(mk(1,0,0,0, 1,0,'h04,0, 1, 0,1,1,0,'h04,0, 0,0,0,0, 14));
    vq.push_back(mk(1,0,0,0, 1,0,'h04,0, 1, 0,1,1,0,'h04,0, 0,0,1,'h12345678, 15));
    vq.push_back(mk(0,0,0,0, 1,0,'h04,0, 1, 0,1,1,0,'h04,0, 0,0,1,'h12345678, 16));
    for (int j = 0; j < 4; j++)
      vq.push_back(mk(1,0,0,0, 1,0,'h04,0, 1, 0,1,1,0,'h04,0, 0,0,1,'h12345678, 16 + j));
    vq.push_back(mk(1,0,0,0, 1,0,'h04,0, 1, 1,0,1,0,0,0, 0,0,1,'h12345678, 20));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,    0, 0,0,0,0,0,0, 1,'hC0DE0000,0,0, 21));
    // Engine write, then cfg write beats a simultaneous engine read (round-robin)
    vq.push_back(mk(0,0,0,0,        1,1,0,'h55AA55AA, 0, 0,1,1,'hf,0,'h55AA55AA, 0,0,0,0, 21));
    vq.push_back(mk(1,1,'h04,'h77,  1,0,0,0,          0, 1,0,1,'hf,'h04,'h77,    0,0,0,0, 21));
    vq.push_back(mk(0,0,0,0,        1,0,0,0,          0, 0,1,1,0,0,0,            0,0,0,0, 22));
    vq.push_back(mk(0,0,0,0,        0,0,0,0,          0, 0,0,0,0,0,0,            0,0,1,'h55AA55AA, 22));

    exp_pipe[0] = 32'h55AA55AA;
    exp_pipe[1] = 32'h00000077;
    for (int i = 2; i < 10; i++) exp_pipe[i] = 32'hC0DE0000 + 32'(i);
    exp_pipe[10] = 32'h000000A5;

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    #12;
    cur = -1;
    check_vec(vq[0]);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table
    for (int i = 0; i < vq.size(); i++) begin
      cur = i;
      apply(vq[i]);
      #3;
      check_vec(vq[i]);
      @(posedge clk); #1;
    end

    // Engine reads 0x00..0x28 back to back
    for (int k = 0; k <= 11; k++) begin
      cur = 100 + k;
      idle_inputs();
      eng_req_valid = (k < 11);
      eng_req_addr  = 12'(k * 4);
      #3;
      chk("pipe_eng_ready", 32'(eng_req_ready), (k < 11) ? 32'd1 : 32'd0);
      chk("pipe_cfg_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
      if (k == 0) begin
        chk("pipe_eng_rsp_valid", 32'(eng_rsp_valid), 32'd0);
      end else begin
        chk("pipe_eng_rsp_valid", 32'(eng_rsp_valid), 32'd1);
        chk("pipe_eng_rsp_rdata", eng_rsp_rdata, exp_pipe[k - 1]);
      end
      @(posedge clk); #1;
    end

    // Reset asserted while a read response is in flight
    cur = 200;
    idle_inputs();
    cfg_req_valid = 1'b1;
    cfg_req_addr  = 12'h000;
    #3;
    chk("rst_pre_cfg_ready", 32'(cfg_req_ready), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    chk("rst_pre_rsp_valid", 32'(cfg_rsp_valid), 32'd1);
    chk("rst_pre_rsp_rdata", cfg_rsp_rdata, 32'h55AA55AA);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid_drop", 32'(cfg_rsp_valid), 32'd0);
    chk("rst_rsp_rdata_drop", cfg_rsp_rdata, 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cfg_rsp", 32'(cfg_rsp_valid), 32'd0);
    chk("post_rst_eng_rsp", 32'(eng_rsp_valid), 32'd0);
    cfg_req_valid = 1'b1; cfg_req_addr = 12'h008;
    eng_req_valid = 1'b1; eng_req_addr = 12'h00C;
    eng_burst     = 1'b0;
    #3;
    chk("post_rst_tie_eng_ready", 32'(eng_req_ready), 32'd1);
    chk("post_rst_tie_cfg_ready", 32'(cfg_req_ready), 32'd0);
    chk("post_rst_tie_bram_A", 32'(bram_A), 32'h00C);
    @(posedge clk); #1;
    idle_inputs();
    #3;
    chk("post_rst_eng_rsp_data", eng_rsp_rdata, 32'hC0DE0003);
    chk("post_rst_conflict_cnt", 32'(conflict_cnt), 32'd1);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
